// File: rtl/pingpong_ctrl.sv
// Ping-pong buffer sequencer: fills one RAM bank while draining the other,
// swapping banks only when the write bank is full and the read bank is empty.
module pingpong_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock_in,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] w_add,
    output logic              wea,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [ADDR_W-1:0] r_add,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              swich_ctrl,
    output logic              frame_done
);

    localparam logic [ADDR_W:0]   FULL_CNT  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FETCH = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;

    logic [ADDR_W:0] w_cnt;
    logic [1:0]      r_state;
    logic            swap;

    assign wr_ready  = (w_cnt != FULL_CNT);
    assign wea       = wr_valid & wr_ready;
    assign w_add     = w_cnt[ADDR_W-1:0];
    assign ram_wdata = wr_data;

    // Swap is decided from registered state only, so a bank that fills on the
    // same edge the last read word leaves swaps one cycle later.
    assign swap = (w_cnt == FULL_CNT) && (r_state == R_IDLE);

    always_ff @(posedge clock_in) begin
        if (rst) begin
            swich_ctrl <= 1'b1;
            w_cnt      <= '0;
        end else if (swap) begin
            swich_ctrl <= ~swich_ctrl;
            w_cnt      <= '0;
        end else if (wea) begin
            w_cnt      <= w_cnt + 1'b1;
        end
    end

    // One outstanding read: r_add is held through R_FETCH so the RAM output
    // can be captured on the following edge.
    always_ff @(posedge clock_in) begin
        if (rst) begin
            r_state    <= R_IDLE;
            r_add      <= '0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    rd_valid <= 1'b0;
                    if (swap) begin
                        r_state <= R_FETCH;
                        r_add   <= '0;
                    end
                end
                R_FETCH: begin
                    rd_data  <= rd_data_in;
                    rd_valid <= 1'b1;
                    r_state  <= R_DATA;
                end
                R_DATA: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (r_add == LAST_ADDR) begin
                            r_add      <= '0;
                            frame_done <= 1'b1;
                            r_state    <= R_IDLE;
                        end else begin
                            r_add   <= r_add + 1'b1;
                            r_state <= R_FETCH;
                        end
                    end
                end
                default: begin
                    r_state  <= R_IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Scoreboard bench for pingpong_ctrl: every accepted upstream word must come out
// downstream once, in order, with directed checks on swap and handshake timing.
module tb_pingpong_ctrl;

    logic       clock_in = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_ready = 1'b0;
    logic       wr_ready, wea, rd_valid, swich_ctrl, frame_done;
    logic [3:0] w_add, r_add;
    logic [7:0] ram_wdata, rd_data, rd_data_in;

    logic [7:0] ram_a [16];
    logic [7:0] ram_b [16];
    logic [7:0] exp_q [$];
    int         tests_run = 0;
    int         tests_failed = 0;
    int         rd_pops = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] wr_next = 8'h10;

    pingpong_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
        .clock_in   (clock_in),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .w_add      (w_add),
        .wea        (wea),
        .ram_wdata  (ram_wdata),
        .r_add      (r_add),
        .rd_data_in (rd_data_in),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_ready   (rd_ready),
        .swich_ctrl (swich_ctrl),
        .frame_done (frame_done)
    );

    always #5 clock_in = ~clock_in;

    // Two-bank RAM behind the crossing switch; read data settles within the fetch cycle.
    always @(posedge clock_in) begin
        if (wea) begin
            if (swich_ctrl) ram_a[w_add] <= ram_wdata;
            else            ram_b[w_add] <= ram_wdata;
        end
    end
    assign rd_data_in = swich_ctrl ? ram_b[r_add] : ram_a[r_add];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic wv, input logic [7:0] wd, input logic rr);
        @(posedge clock_in);
        #1;
        rst      = r;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        @(negedge clock_in);
    endtask

    // Scoreboard: push on accepted write, pop on downstream handshake, and
    // require rd_valid/rd_data to hold across a stalled cycle.
    always @(negedge clock_in) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                checkOutput("hold_valid", rd_valid, 1);
                checkOutput("hold_data", rd_data, prev_data);
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) checkOutput("sb_underflow", 1, 0);
                else checkOutput("rd_data", rd_data, exp_q.pop_front());
                rd_pops++;
            end
            if (wr_valid && wr_ready) exp_q.push_back(wr_data);
            prev_hold = rd_valid && !rd_ready;
            prev_data = rd_data;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  stall_left = 0;
        int  resume = 0;
        int  start_pops;
        int  written;
        bit  bp_done = 0;
        bit  seen = 0;
        bit  last_next = 0;
        logic rr;
        logic wv;

        applyStimulus(1, 0, 8'h00, 0);
        applyStimulus(1, 0, 8'h00, 0);
        checkOutput("rst_swich", swich_ctrl, 1);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_r_add", r_add, 0);
        checkOutput("rst_rd_data", rd_data, 0);
        checkOutput("rst_frame_done", frame_done, 0);
        checkOutput("rst_wr_ready", wr_ready, 1);

        // First frame: 16 back-to-back writes into bank A.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, wr_next, 1);
            checkOutput("fill_wea", wea, 1);
            checkOutput("fill_w_add", w_add, i);
            wr_next++;
        end
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("full_wr_ready", wr_ready, 0);
        checkOutput("full_swich_pre", swich_ctrl, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("swap1_swich", swich_ctrl, 0);
        checkOutput("swap1_r_add", r_add, 0);
        checkOutput("swap1_rd_valid", rd_valid, 0);

        // Drain bank A with a 5-cycle stall at word 3 while the writer outruns the reader.
        start_pops = rd_pops;
        for (int i = 0; i < 120; i++) begin
            rr = (stall_left == 0);
            applyStimulus(0, 1, wr_next, rr);
            if (wr_ready) wr_next++;
            if (i == 0) checkOutput("first_rd_valid", rd_valid, 1);
            if (resume == 1) begin
                checkOutput("bp_resume_r_add", r_add, 4);
                checkOutput("bp_resume_valid", rd_valid, 0);
            end
            if (resume > 0) resume--;
            if (!rr) begin
                checkOutput("bp_r_add", r_add, 3);
                checkOutput("bp_rd_valid", rd_valid, 1);
                stall_left--;
                if (stall_left == 0) resume = 2;
            end else if (!bp_done && r_add == 4'd3 && !rd_valid) begin
                stall_left = 5;
                bp_done = 1;
            end
            if (frame_done) begin
                seen = 1;
                checkOutput("fd1_words", rd_pops - start_pops, 16);
                checkOutput("fd1_swich_hold", swich_ctrl, 0);
                checkOutput("fd1_wr_stalled", wr_ready, 0);
                break;
            end
        end
        checkOutput("fd1_seen", seen, 1);
        checkOutput("bp_seen", bp_done, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("swap2_swich", swich_ctrl, 1);
        checkOutput("fd1_pulse_width", frame_done, 0);
        checkOutput("swap2_wr_ready", wr_ready, 1);

        // Line up the 16th write with the final read handshake of bank B.
        written = 0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            wv = (written < 15) || last_next;
            applyStimulus(0, wv, wr_next, 1);
            if (wv && wr_ready) begin
                wr_next++;
                written++;
            end
            if (last_next) begin
                seen = 1;
                checkOutput("sim_rd_valid", rd_valid, 1);
                checkOutput("sim_r_add", r_add, 15);
                checkOutput("sim_wea", wea, 1);
                checkOutput("sim_w_add", w_add, 15);
                break;
            end
            last_next = (r_add == 4'd15) && !rd_valid && (written == 15);
        end
        checkOutput("sim_seen", seen, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("sim_frame_done", frame_done, 1);
        checkOutput("sim_wr_ready", wr_ready, 0);
        checkOutput("sim_swich_pre", swich_ctrl, 1);
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("sim_swap_swich", swich_ctrl, 0);
        checkOutput("sim_swap_r_add", r_add, 0);
        checkOutput("sim_swap_rd_valid", rd_valid, 0);

        // Reset in the middle of draining, around word 7.
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 0, 8'h00, 1);
            if (r_add == 4'd7 && rd_valid) begin
                seen = 1;
                break;
            end
        end
        checkOutput("mid_word7_seen", seen, 1);
        applyStimulus(1, 0, 8'h00, 1);
        exp_q.delete();
        applyStimulus(0, 0, 8'h00, 1);
        checkOutput("mid_rst_rd_valid", rd_valid, 0);
        checkOutput("mid_rst_swich", swich_ctrl, 1);
        checkOutput("mid_rst_r_add", r_add, 0);
        checkOutput("mid_rst_w_add", w_add, 0);
        checkOutput("mid_rst_wr_ready", wr_ready, 1);

        // Fresh frame after reset must drain exactly the new words.
        written = 0;
        seen = 0;
        start_pops = rd_pops;
        for (int i = 0; i < 100; i++) begin
            wv = (written < 16);
            applyStimulus(0, wv, wr_next, 1);
            if (wv && wr_ready) begin
                wr_next++;
                written++;
            end
            if (frame_done) begin
                seen = 1;
                break;
            end
        end
        checkOutput("post_rst_fd_seen", seen, 1);
        checkOutput("post_rst_words", rd_pops - start_pops, 16);
        checkOutput("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
